// File: rtl/onehot_key_scanner_if.sv
// onehot_key_scanner_if: button scanner bus; the master side presents the accepted one-hot key
interface onehot_key_scanner_if;
  logic [7:0] key_raw;
  logic [7:0] key_onehot;
  logic       key_valid;
  logic       key_err;
  logic       busy;
  modport master (input key_raw, output key_onehot, key_valid, key_err, busy);
  modport slave  (output key_raw, input key_onehot, key_valid, key_err, busy);
endinterface

// File: rtl/onehot_key_scanner.sv
// onehot_key_scanner: synchronise and debounce 8 buttons, pass only single-key presses as a legal one-hot vector.
// Auto-repeat of the held key is built only when KEY_REPEAT_EN is defined.
module onehot_key_scanner #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CNT        = 16,
  parameter int REPEAT_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  onehot_key_scanner_if.master bus
);
  localparam int CW = $clog2(DB_CNT + 1);
  if (SYNC_STAGES < 2 || DB_CNT < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("onehot_key_scanner: illegal parameter value");
  end
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, REJECT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] sync_in, cand;
  logic [CW-1:0] cnt, rel_cnt;
  logic zero, multi, rel_done;
  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign zero     = sync_in == 8'h00;
  assign multi    = (sync_in & (sync_in - 8'd1)) != 8'h00;
  assign rel_done = zero && rel_cnt == CW'(DB_CNT - 1);
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rpt_cnt;
  logic rpt_hold, rpt_fire;
  assign rpt_hold = state == PRESSED && sync_in == bus.key_onehot;
  assign rpt_fire = rpt_hold && rpt_cnt == RW'(REPEAT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rpt_cnt <= '0;
    else rpt_cnt <= (rpt_hold && !rpt_fire) ? rpt_cnt + 1'b1 : '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q         <= '0;
      state          <= IDLE;
      cand           <= '0;
      cnt            <= '0;
      rel_cnt        <= '0;
      bus.key_onehot <= 8'h80;
      bus.key_valid  <= 1'b0;
      bus.key_err    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.key_raw};
      bus.key_valid <= 1'b0;
      bus.key_err   <= 1'b0;
      case (state)
        IDLE:
          if (multi) begin
            bus.key_err <= 1'b1;
            rel_cnt     <= '0;
            state       <= REJECT;
            bus.busy    <= 1'b1;
          end else if (!zero) begin
            cand     <= sync_in;
            cnt      <= CW'(1);
            state    <= DEBOUNCE;
            bus.busy <= 1'b1;
          end
        DEBOUNCE:
          if (multi) begin
            bus.key_err <= 1'b1;
            rel_cnt     <= '0;
            state       <= REJECT;
          end else if (zero) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (sync_in != cand) begin
            cand <= sync_in;
            cnt  <= CW'(1);
          end else if (cnt == CW'(DB_CNT - 1)) begin
            bus.key_onehot <= cand;
            bus.key_valid  <= 1'b1;
            rel_cnt        <= '0;
            state          <= PRESSED;
          end else cnt <= cnt + 1'b1;
        default: begin
          // PRESSED and REJECT share the release rule; extra keys only reset the release count
          rel_cnt <= zero ? rel_cnt + 1'b1 : '0;
          if (rel_done) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
`ifdef KEY_REPEAT_EN
          if (rpt_fire) bus.key_valid <= 1'b1;
`endif
        end
      endcase
    end
endmodule

// File: tb/tb_onehot_key_scanner.sv
// tb_onehot_key_scanner: run-length reference model checked every cycle plus directed latency checks.
module tb_onehot_key_scanner;
  localparam int SS = 2, DB = 4, RC = 50;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  onehot_key_scanner_if bus();
  onehot_key_scanner #(.SYNC_STAGES(SS), .DB_CNT(DB), .REPEAT_CYCLES(RC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0, vcnt = 0, ecnt = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef enum {FREE, HELD, LOCKED} mode_t;
  mode_t mode;
  logic [7:0] pipe[$];
  logic [7:0] s, prev, m_onehot;
  logic m_valid, m_err, m_busy;
  int run, rep;
  // Model: a key is accepted once DB identical one-hot samples have been seen while free;
  // a held or rejected press ends after DB consecutive empty samples.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe = {};
      for (int i = 0; i < SS; i++) pipe.push_back(8'h00);
      mode = FREE; run = 0; rep = 0; prev = 8'h00;
      m_onehot = 8'h80; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else begin
      pipe.push_back(bus.key_raw);
      s = pipe.pop_front();
      run = (s == prev) ? run + 1 : 1;
      prev = s;
      m_valid = 1'b0; m_err = 1'b0;
      if (mode == FREE) begin
        if ($countones(s) > 1) begin m_err = 1'b1; mode = LOCKED; end
        else if ($countones(s) == 1 && run == DB) begin m_valid = 1'b1; m_onehot = s; mode = HELD; rep = 0; end
      end else if (s == 8'h00 && run == DB) mode = FREE;
      else if (mode == HELD) begin
        rep = (s == m_onehot) ? rep + 1 : 0;
`ifdef KEY_REPEAT_EN
        if (rep > 0 && rep % RC == 0) m_valid = 1'b1;
`endif
      end
      m_busy = mode != FREE || $countones(s) == 1;
    end
  always @(negedge clk) begin
    chk("onehot", bus.key_onehot, m_onehot);
    chk("valid", bus.key_valid, m_valid);
    chk("err", bus.key_err, m_err);
    chk("busy", bus.busy, m_busy);
    if (bus.key_valid) vcnt++;
    if (bus.key_err) ecnt++;
  end
  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.key_valid) begin k = i; break; end
    end
  endtask
  task automatic wait_idle(output int k);
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin k = i; break; end
    end
  endtask
  task automatic drive(logic [7:0] v, int n);
    @(negedge clk);
    bus.key_raw = v;
    repeat (n - 1) @(negedge clk);
  endtask
  initial begin
    int k, v0, e0, d;
    logic [7:0] v;
    bus.key_raw = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_onehot", bus.key_onehot, 8'h80);
    chk("rst_busy", bus.busy, 1'b0);
    bus.key_raw = 8'h04;
    wait_valid(k);
    chk("clean_latency", k, SS + DB);
    chk("clean_onehot", bus.key_onehot, 8'h04);
    drive(8'h04, 14);
    drive(8'h00, 1);
    wait_idle(k);
    chk("release_latency", k, SS + DB);
    drive(8'h00, 4);
    v0 = vcnt;
    for (int i = 0; i < 6; i++) drive(i % 2 == 0 ? 8'h10 : 8'h00, 2);
    chk("bounce_no_valid", vcnt - v0, 0);
    @(negedge clk);
    bus.key_raw = 8'h10;
    wait_valid(k);
    chk("bounce_latency", k, DB + 2);
    chk("bounce_onehot", bus.key_onehot, 8'h10);
    drive(8'h00, 12);
    v0 = vcnt; e0 = ecnt;
    drive(8'h81, 10);
    chk("multi_err_count", ecnt - e0, 1);
    chk("multi_no_valid", vcnt - v0, 0);
    chk("multi_onehot_kept", bus.key_onehot, 8'h10);
    drive(8'h00, 1);
    wait_idle(k);
    chk("multi_release", k, SS + DB);
    @(negedge clk);
    bus.key_raw = 8'h02;
    wait_valid(k);
    chk("after_multi_latency", k, SS + DB);
    chk("after_multi_onehot", bus.key_onehot, 8'h02);
    drive(8'h00, 12);
    bus.key_raw = 8'h20;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_onehot", bus.key_onehot, 8'h80);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_valid", bus.key_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(k);
    chk("arst_redebounce", k, SS + DB);
    chk("arst_onehot_new", bus.key_onehot, 8'h20);
    drive(8'h00, 12);
    v0 = vcnt;
    drive(8'h08, 200);
`ifdef KEY_REPEAT_EN
    chk("repeat_pulses", vcnt - v0, 4);
`else
    chk("repeat_pulses", vcnt - v0, 1);
`endif
    drive(8'h00, 12);
    for (int seg = 0; seg < 350; seg++) begin
      k = $urandom_range(0, 9);
      d = $urandom_range(1, 12);
      v = 8'h01 << $urandom_range(0, 7);
      if (k == 4) v = v | (8'h01 << $urandom_range(0, 7));
      else if (k == 5 || k == 6) v = 8'h00;
      else if (k == 9) v = 8'($urandom);
      if (k == 7 || k == 8)
        for (int j = 0; j < d; j++) drive(j % 2 == 0 ? v : 8'h00, $urandom_range(1, 3));
      else drive(v, d + (k < 4 ? DB : 0));
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    drive(8'h00, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/onehot_key_scanner.md
Name: onehot_key_scanner

Overview:
- Front-end stage feeding the 8-to-3 one-hot encoder.
- Takes 8 raw, asynchronous, bouncing push-button lines, synchronises and debounces them, and accepts only single-key presses.
- Presents a registered, always-legal one-hot vector plus a one-cycle valid strobe. The downstream encoder therefore never sees zero or multi-hot input.

Parameters:
- SYNC_STAGES, 2, synchroniser flop depth per input bit; minimum 2.
- DB_CNT, 16, number of consecutive identical synchronised samples needed to accept a press or a release; minimum 2.
- REPEAT_CYCLES, 1024, auto-repeat period in clocks; used only when KEY_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- key_raw  input  8  raw buttons, active-high, asynchronous. Bit 7 is key 0 and bit 0 is key 7, matching the encoder's MSB-first code order.
- key_onehot  output  8  registered accepted key, always exactly one bit set.
- key_valid  output  1  one-cycle pulse when key_onehot is updated by an accepted press.
- key_err  output  1  one-cycle pulse when a multi-key press is detected.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops = 0, state = IDLE, counters = 0.
  - key_onehot = 8'b10000000, key_valid = 0, key_err = 0, busy = 0.
  - Reset asserted mid-debounce or mid-press aborts with no valid or err pulse.
- sync_in: key_raw after SYNC_STAGES flops. All decisions use sync_in only.
- Classification of sync_in: ZERO (no bits set), SINGLE (exactly one bit set), MULTI (two or more bits set).
- FSM states: IDLE, DEBOUNCE, PRESSED, REJECT.
- IDLE:
  - SINGLE: cand <= sync_in, cnt <= 1, go to DEBOUNCE.
  - MULTI: pulse key_err, go to REJECT.
  - ZERO: stay.
- DEBOUNCE:
  - sync_in == cand: cnt++. When cnt reaches DB_CNT: key_onehot <= cand, pulse key_valid, rel_cnt <= 0, go to PRESSED.
  - ZERO: back to IDLE, no outputs.
  - Different SINGLE: cand <= sync_in, cnt <= 1, stay.
  - MULTI: pulse key_err, go to REJECT.
- PRESSED:
  - ZERO: rel_cnt++. When rel_cnt reaches DB_CNT, go to IDLE.
  - Any nonzero: rel_cnt <= 0.
  - Extra keys pressed while held are ignored: no err, no new valid.
- REJECT: same release rule as PRESSED. Exit to IDLE only after DB_CNT consecutive ZERO samples.
- Latency: raw key stable from before edge 1 gives key_valid high in the cycle after edge SYNC_STAGES+DB_CNT. With defaults that is edge 18.
- key_onehot holds its last accepted value indefinitely. It changes only on the same edge that raises key_valid.
- key_valid and key_err are registered, exactly one cycle wide, and never asserted together.
- Counter width is $clog2(DB_CNT+1) and counters saturate. No wrap is possible because every counter compare is an exit condition.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter runs while sync_in == key_onehot.
  - Every REPEAT_CYCLES cycles it pulses key_valid again, with key_onehot unchanged.
  - The counter clears on any other sync_in value and on entry to PRESSED.
  - The first repeat comes REPEAT_CYCLES cycles after the initial key_valid.
- Not defined: no repeat logic is synthesised, REPEAT_CYCLES is ignored, and exactly one key_valid is produced per press.

Test Plan:
- Reset check: rst_n=0 then released with no keys -> key_onehot=8'h80, key_valid=0, key_err=0, busy=0 for 100 cycles.
- Clean press (DB_CNT=4, SYNC_STAGES=2): key_raw=8'h04 held 20 cycles -> key_valid single pulse after edge 6, key_onehot=8'h04. Release -> busy drops 4 cycles after sync_in goes 0.
- Bounce: key_raw toggles 8'h10/8'h00 every 2 cycles for 12 cycles, then holds 8'h10 -> no key_valid during the bounce, one pulse DB_CNT+2 cycles after it settles, key_onehot=8'h10.
- Multi-key: key_raw=8'h81 -> key_err single pulse, no key_valid, key_onehot unchanged. After release to 0 plus DB_CNT cycles, pressing 8'h02 is accepted normally.
- Async reset mid-debounce: rst_n low 1 cycle while in DEBOUNCE on key 8'h20 -> outputs immediately at reset values, no key_valid. Re-debounce from scratch after reset.
- With KEY_REPEAT_EN and REPEAT_CYCLES=50: hold 8'h08 for 200 cycles -> key_valid at edge 6, then at 56, 106 and 156. Without the macro -> one pulse only.
